fp_sub_seq: RTL

FP_SUB_SEQ -- requirements
Module: fp_sub_seq

---
 rtl/fp_sub_seq_pkg.sv | 23 ++
 rtl/fp_sub_seq_norm_step.sv | 31 +++
 rtl/fp_sub_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_sub_seq_pkg.sv
// Shared FPU definitions for the sequential binary64 subtractor:
// field widths, special encodings and the FSM state enumeration.
package fp_sub_seq_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NEG_INF = 64'hFFF0_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_sub_seq_norm_step.sv
// fp_norm_step: one normalization step, shifting left by up to N places.
// Ports: mant/exp in, mant_o/exp_o stepped, done = stepped value final.
module fp_norm_step #(
  parameter int N = 1
) (
  input  logic [55:0] mant,
  input  logic [11:0] exp,
  output logic [55:0] mant_o,
  output logic [11:0] exp_o,
  output logic        done
);

  logic [3:0] sh;
  logic       stop;

  always_comb begin
    sh   = '0;
    stop = 1'b0;
    // Shift only through leading zeros and never below exponent 1.
    for (int i = 0; i < N; i++) begin
      if (!stop && !mant[55-i] && (exp > 12'(i + 1)))
        sh = 4'(i + 1);
      else
        stop = 1'b1;
    end
    mant_o = mant << sh;
    exp_o  = exp - {8'd0, sh};
    done   = mant_o[55] | (exp_o <= 12'd1) | (mant_o == '0);
  end

endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle binary64 out = in1 - in2, valid/ready in and out.
// Ports: clk, rst, in_valid/in_ready/in1/in2, out_valid/out_ready/out;
// flags[2:0] = {invalid, overflow, inexact} when FP_SUB_FLAGS_EN is defined.
module fp_sub_seq
  import fp_sub_seq_pkg::*;
#(
  parameter int NORM_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out
`ifdef FP_SUB_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  state_t state, state_nx;

  logic [63:0] a_q, b_q;
  logic        sgn_q, sub_q;
  logic [11:0] exp_q;
  logic [55:0] ma_q, mb_q, m_q;
  logic [63:0] out_q;

  // Special operands, decoded straight from the inputs at accept
  logic [EXP_W-1:0] e1, e2;
  logic nan1, nan2, inf1, inf2, special, spec_inv;
  logic [63:0] spec_val;

  assign e1   = in1[62:52];
  assign e2   = in2[62:52];
  assign nan1 = (e1 == EXP_MAX) &&  (|in1[FRAC_W-1:0]);
  assign nan2 = (e2 == EXP_MAX) &&  (|in2[FRAC_W-1:0]);
  assign inf1 = (e1 == EXP_MAX) && !(|in1[FRAC_W-1:0]);
  assign inf2 = (e2 == EXP_MAX) && !(|in2[FRAC_W-1:0]);
  assign special = nan1 | nan2 | inf1 | inf2;
  assign spec_inv = nan1 | nan2 |
                    (inf1 & inf2 & (in1[63] == in2[63]));

  always_comb begin
    spec_val = QNAN;
    if (!spec_inv) begin
      if (inf1)
        spec_val = in1;
      else
        spec_val = in2[63] ? POS_INF : NEG_INF;
    end
  end

  // Align: unpack, order by magnitude, shift the smaller with sticky
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [55:0] fa, fb, f_big, f_sml, mask, f_shr;
  logic [5:0]  sh;
  logic        swap, s_big;

  always_comb begin
    ea    = (a_q[62:52] == '0) ? 11'd1 : a_q[62:52];
    eb    = (b_q[62:52] == '0) ? 11'd1 : b_q[62:52];
    fa    = {|a_q[62:52], a_q[51:0], 3'b000};
    fb    = {|b_q[62:52], b_q[51:0], 3'b000};
    swap  = b_q[62:0] > a_q[62:0];
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    f_big = swap ? fb : fa;
    f_sml = swap ? fa : fb;
    s_big = swap ? ~b_q[63] : a_q[63];
    diff  = e_big - e_sml;
    sh    = (diff > 11'd56) ? 6'd56 : diff[5:0];
    mask  = ~({56{1'b1}} << sh);
    f_shr = (f_sml >> sh) | {55'd0, |(f_sml & mask)};
  end

  // Op: magnitude add/subtract, fold a carry back into 56 bits
  logic [56:0] sum;
  logic [55:0] op_m;
  logic [11:0] op_e;

  always_comb begin
    sum  = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                 : ({1'b0, ma_q} + {1'b0, mb_q});
    op_m = sum[55:0];
    op_e = exp_q;
    if (sum[56]) begin
      op_m = {sum[56:2], sum[1] | sum[0]};
      op_e = exp_q + 12'd1;
    end
  end

  logic [55:0] norm_m;
  logic [11:0] norm_e;
  logic        norm_done;

  fp_norm_step #(
    .N(NORM_BITS_PER_CYCLE)
  ) u_norm (
    .mant  (m_q),
    .exp   (exp_q),
    .mant_o(norm_m),
    .exp_o (norm_e),
    .done  (norm_done)
  );

  // Round to nearest even, then pack
  logic        rnd_up, rnd_ovf, rnd_inx;
  logic [53:0] sig;
  logic [52:0] sig_n;
  logic [11:0] e_r;
  logic [63:0] rnd_val;

  always_comb begin
    rnd_up  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rnd_inx = |m_q[2:0];
    sig     = {1'b0, m_q[55:3]} + {53'd0, rnd_up};
    sig_n   = sig[52:0];
    e_r     = exp_q;
    if (sig[53]) begin
      sig_n = sig[53:1];
      e_r   = exp_q + 12'd1;
    end
    rnd_ovf = 1'b0;
    if (m_q == '0) begin
      rnd_val = 64'd0;
    end else if (e_r >= 12'd2047) begin
      rnd_val = sgn_q ? NEG_INF : POS_INF;
      rnd_ovf = 1'b1;
    end else begin
      rnd_val = {sgn_q, sig_n[52] ? e_r[10:0] : 11'd0, sig_n[51:0]};
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = special ? DONE : ALIGN;
      ALIGN: state_nx = OP;
      OP:    state_nx = NORM;
      NORM:  if (norm_done) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers; only meaningful while an operation is in flight
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_q <= in1;
          b_q <= in2;
        end
      end
      ALIGN: begin
        sgn_q <= s_big;
        sub_q <= a_q[63] == b_q[63];
        exp_q <= {1'b0, e_big};
        ma_q  <= f_big;
        mb_q  <= f_shr;
      end
      OP: begin
        m_q   <= op_m;
        exp_q <= op_e;
      end
      NORM: begin
        m_q   <= norm_m;
        exp_q <= norm_e;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (state == IDLE && in_valid && special) begin
      out_q <= spec_val;
    end else if (state == ROUND) begin
      out_q <= rnd_val;
    end
  end

`ifdef FP_SUB_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state == IDLE && in_valid && special) begin
      flags_q <= {spec_inv, 2'b00};
    end else if (state == ROUND) begin
      flags_q <= {1'b0, rnd_ovf, rnd_inx | rnd_ovf};
    end
  end

  assign flags = flags_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_q;

endmodule
